spi_slave_rx: RTL
=================

# spi_slave_rx

Receive-side SPI responder for the board's 16-bit configuration link. It samples `spi_clk`/`spi_csn`/`spi_sdi` from an SPI master using the 50 MHz system clock, assembles MSB-first 16-bit frames, and writes each completed frame into an external 32-entry register RAM at an auto-incrementing address. It also shifts the previous frame back out on `spi_sdo` for loopback checking, and flags completion after 32 frames. It sits beside the configuration target as the device-side model and bring-up endpoint.

## Interface
- `FRAME_BITS`, 16, bits per frame, MSB first.
- `ADDR_W`, 5, write-address width; depth = 2**ADDR_W = 32 frames.
- `sclk` in 1: system clock, 50 MHz; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `spi_clk` in 1: SPI clock from the master, idle low; asynchronous to `sclk`.
- `spi_csn` in 1: chip select, active low; asynchronous.
- `spi_sdi` in 1: serial data from the master; the master changes it on the `spi_clk` falling edge.
- `spi_sdo` out 1: serial readback to the master.
- `wr_en` out 1: one-cycle write strobe to the register RAM.
- `wr_addr` out ADDR_W: write address.
- `wr_data` out FRAME_BITS: write data.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `rx_end` out 1: high once 32 frames have been stored; stays high until reset.

## Operation
- Input conditioning: `spi_clk`, `spi_csn`, and `spi_sdi` each pass through two synchronizing flops plus one history flop. `clk_rise` = s2 & ~s3 of `spi_clk`. `clk_fall` = ~s2 & s3. `cs_act` = ~s2 of `spi_csn`. The `spi_sdi` sample is taken from its s2, which keeps it aligned with the `clk_rise` detection.
- States:
  - IDLE: go to SHIFT when `cs_act` = 1.
  - SHIFT: on each `clk_rise`, shift_reg <= {shift_reg[14:0], sdi_s2} and bit_cnt += 1. When `clk_rise` occurs with bit_cnt = 15, go to STORE.
  - STORE: one cycle, then go to HOLD, or to DONE if wr_addr was 31.
  - HOLD: wait for `cs_act` = 0, then go to IDLE. Edges seen in HOLD are ignored.
  - DONE: absorbing state until reset; no further writes.
- Abort: if `cs_act` falls in SHIFT with bit_cnt ≠ 0 or a partial shift in progress, pulse `frame_err`, discard the data, and go to IDLE. `wr_addr` does not advance. Deassertion with bit_cnt = 0 and no rise seen returns to IDLE silently.
- Write: in STORE, `wr_en` = 1 and `wr_data` = the completed shift_reg. `wr_addr` increments on the cycle after STORE. The increment goes 31→0, and that wrap sets `rx_end`.
- Readback: `tx_reg` holds the last stored word; it is 16'h0000 after reset.
  - On entry to SHIFT, `spi_sdo` presents tx_reg[15].
  - Each `clk_fall` in SHIFT shifts tx_reg left; `spi_sdo` = tx_reg[15].
  - `spi_sdo` = 0 outside SHIFT.
  - tx_reg reloads from shift_reg in STORE.
- `bit_cnt` clears whenever the state is not SHIFT.

## Timing
- Reset values: `spi_sdo`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_err`=0, `rx_end`=0. State = IDLE, all synchronizer flops are 0, and `spi_csn` syncs reset to 1 (inactive).
- Input latency: a `spi_clk` edge is acted on 3 `sclk` edges after it is sampled.
- `wr_en` asserts in the cycle immediately after the `sclk` edge that shifts in the 16th bit. Its width is exactly 1 cycle, and `wr_data` is stable during it.
- `spi_clk` high and low times must each be ≥ 4 `sclk` cycles. The master's 25-cycle half period satisfies this.
- `spi_csn` must stay low ≥ 4 `sclk` cycles after the last `spi_clk` fall. It must stay high ≥ 4 cycles between frames.
- Output `spi_sdo` lags the `spi_clk` fall by 3–4 `sclk` cycles, which is well inside the half period.
- Simultaneous `cs_act` deassert and the 16th `clk_rise` in the same cycle: the frame is stored (STORE wins) and no `frame_err` is raised.
- `rst` asserted mid-frame: all outputs return to reset values immediately (asynchronously). Partial data is lost and `wr_addr` returns to 0.

## Structure
- Package `spi_pkg`: state encodings (one-hot 5-bit, matching the team's FSM style), FRAME_BITS, DEPTH.
- Sub-module `spi_in_sync`: a 3-flop synchronizer with rise/fall outputs, instantiated once per SPI input.
- The register RAM is outside this block.

## Test plan
- Single frame: send 16'hA55A with CS low → one `wr_en` pulse with wr_addr=0 and wr_data=16'hA55A; `frame_err`=0.
- Readback: send 16'h1234, then 16'h0000 → `spi_sdo` bits during the second frame spell 16'h1234 MSB-first.
- Abort: drop CS after 9 bits, then send 16'hBEEF → one `frame_err` pulse and no write for the aborted frame; 16'hBEEF is written at address 0.
- Full run: send 32 frames with data = address×16'h0101 → 32 writes at addresses 0..31; `rx_end` rises after the 32nd; a 33rd frame produces no write.
- Boundary: CS deasserted in the same cycle as the 16th synchronized rise → the frame is stored and `frame_err`=0.
- Reset mid-frame: assert `rst` after 8 bits, release it, then send 16'h00FF → all outputs at reset values during reset; 16'h00FF is written at address 0.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI receive responder
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  // One-hot frame sequencer states
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SHIFT = 5'b00010,
    ST_STORE = 5'b00100,
    ST_HOLD  = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - SPI pins plus register-RAM write port of the receive responder
interface spi_slave_rx_if;
  import spi_pkg::*;

  logic                  spi_clk;
  logic                  spi_csn;
  logic                  spi_sdi;
  logic                  spi_sdo;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [FRAME_BITS-1:0] wr_data;
  logic                  frame_err;
  logic                  rx_end;

  modport master (
    output spi_clk, spi_csn, spi_sdi,
    input  spi_sdo, wr_en, wr_addr, wr_data, frame_err, rx_end
  );

  modport slave (
    input  spi_clk, spi_csn, spi_sdi,
    output spi_sdo, wr_en, wr_addr, wr_data, frame_err, rx_end
  );

endinterface

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - two-flop synchronizer plus history flop with edge outputs
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronize the asynchronous input and keep one cycle of history for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI frame receiver writing 16-bit words to an external register RAM
module spi_slave_rx
  import spi_pkg::*;
(
  input  logic           sclk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);

  logic clk_lvl, clk_rise, clk_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic cs_act;

  spi_in_sync #(.RST_VAL(1'b0)) u_sync_clk (
    .clk_i(sclk), .rst_i(rst), .d_i(bus.spi_clk),
    .lvl_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  // Chip select idles high, so its synchronizer comes out of reset inactive
  spi_in_sync #(.RST_VAL(1'b1)) u_sync_csn (
    .clk_i(sclk), .rst_i(rst), .d_i(bus.spi_csn),
    .lvl_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  // Data is taken from the same synchronizer depth as the clock so it lines up with clk_rise
  spi_in_sync #(.RST_VAL(1'b0)) u_sync_sdi (
    .clk_i(sclk), .rst_i(rst), .d_i(bus.spi_sdi),
    .lvl_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, clk_lvl, csn_rise, csn_fall, sdi_rise, sdi_fall};

  assign cs_act = ~csn_lvl;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] tx_q;
  logic [FRAME_BITS-1:0] txs_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  rx_end_q;
  logic                  frame_err_q;
  logic                  abort;
  logic                  last_bit;
  logic                  last_addr;

  assign last_bit  = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
  assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));

  // State register
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the 16th rise outranks a simultaneous chip-select release
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_act) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_rise && last_bit) begin
          state_d = ST_STORE;
        end else if (!cs_act) begin
          state_d = ST_IDLE;
          abort   = (bit_cnt_q != '0) || clk_rise;
        end
      end
      ST_STORE: begin
        state_d = last_addr ? ST_DONE : ST_HOLD;
      end
      ST_HOLD: begin
        if (!cs_act) state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: shift in data, shift out readback, advance the write address after each store
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      txs_q       <= '0;
      addr_q      <= '0;
      rx_end_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= abort;
      if (state_q == ST_SHIFT) begin
        if (clk_rise) begin
          shift_q   <= {shift_q[FRAME_BITS-2:0], sdi_lvl};
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        if (clk_fall) begin
          txs_q <= {txs_q[FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        bit_cnt_q <= '0;
        // Working copy so an aborted frame never disturbs the last stored word
        if (state_d == ST_SHIFT) txs_q <= tx_q;
      end
      if (state_q == ST_STORE) begin
        tx_q   <= shift_q;
        addr_q <= addr_q + 1'b1;
        if (last_addr) rx_end_q <= 1'b1;
      end
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.spi_sdo = 1'b0;
    if (state_q == ST_STORE) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = shift_q;
    end
    if (state_q == ST_SHIFT) begin
      bus.spi_sdo = txs_q[FRAME_BITS-1];
    end
  end

  assign bus.wr_addr   = addr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_end    = rx_end_q;

endmodule
